// File: rtl/imm_gen_pipe.sv
// Pipelined RV immediate generator: combinational decode into a 2-entry output FIFO.
// Optional CSR-immediate (Z-format) decode is enabled by defining IMM_GEN_CSR_EN.
module imm_gen_pipe #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    fmt_e             fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [31:0] imm32;
  fmt_e        dec_fmt;
  logic        dec_illegal;
  entry_t      dec_entry;

  // Every format is assembled as a 32-bit value first; bit 31 always carries
  // instr[31] (or 0 for Z), so one sign-extending cast covers both XLENs.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    imm32       = '0;
    dec_fmt     = FMT_NONE;
    dec_illegal = 1'b1;
    case (in_instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: begin
        imm32       = {{20{in_instr[31]}}, in_instr[31:20]};
        dec_fmt     = FMT_I;
        dec_illegal = 1'b0;
      end
      7'b0011011: begin
        if (XLEN == 64) begin
          imm32       = {{20{in_instr[31]}}, in_instr[31:20]};
          dec_fmt     = FMT_I;
          dec_illegal = 1'b0;
        end
      end
      7'b0100011: begin
        imm32       = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        dec_fmt     = FMT_S;
        dec_illegal = 1'b0;
      end
      7'b1100011: begin
        imm32       = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                       in_instr[30:25], in_instr[11:8], 1'b0};
        dec_fmt     = FMT_B;
        dec_illegal = 1'b0;
      end
      7'b0110111, 7'b0010111: begin
        imm32       = {in_instr[31:12], 12'b0};
        dec_fmt     = FMT_U;
        dec_illegal = 1'b0;
      end
      7'b1101111: begin
        imm32       = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                       in_instr[20], in_instr[30:21], 1'b0};
        dec_fmt     = FMT_J;
        dec_illegal = 1'b0;
      end
`ifdef IMM_GEN_CSR_EN
      7'b1110011: begin
        dec_illegal = 1'b0;
        if (in_instr[14:12] != 3'b000) begin
          imm32   = {27'b0, in_instr[19:15]};
          dec_fmt = FMT_Z;
        end
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    dec_entry         = '0;
    dec_entry.imm     = XLEN'($signed(imm32));
    dec_entry.fmt     = dec_fmt;
    dec_entry.illegal = dec_illegal;
    dec_entry.tag     = in_tag;
  end

  entry_t     mem_q [2];
  logic [1:0] count_q, count_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic       push, pop;

  // in_ready depends on registered state only, never on out_ready.
  assign in_ready  = (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: ;
    endcase
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; stale contents are invisible because outputs are gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dec_entry;
  end

  entry_t head;
  assign head        = mem_q[rd_ptr_q];
  assign out_imm     = out_valid ? head.imm     : '0;
  assign out_fmt     = out_valid ? head.fmt     : FMT_NONE;
  assign out_illegal = out_valid ? head.illegal : 1'b0;
  assign out_tag     = out_valid ? head.tag     : '0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: XLEN=64 and XLEN=32 instances fed the same
// stimulus; decode vectors from a table, plus backpressure, stream and reset sequences.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [3:0]  in_tag;
  logic        out_ready;

  logic        in_ready, out_valid, out_illegal;
  logic [63:0] out_imm;
  logic [2:0]  out_fmt;
  logic [3:0]  out_tag;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32;
  logic [2:0]  out_fmt32;
  logic [3:0]  out_tag32;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(64), .TAG_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_fmt(out_fmt), .out_illegal(out_illegal), .out_tag(out_tag)
  );

  imm_gen_pipe #(.XLEN(32), .TAG_W(4)) u_dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
    .out_fmt(out_fmt32), .out_illegal(out_illegal32), .out_tag(out_tag32)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic        ill64;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic        ill32;
  } vec_t;

  vec_t tbl [14];

  // Scoreboard for the multi-cycle sequences; expected immediates come from the driver.
  typedef struct {
    logic [3:0]  tag;
    logic [63:0] imm;
  } sb_t;

  sb_t         sb_q[$];
  logic [3:0]  pop_log[$];
  logic        sb_en = 1'b0;
  logic [63:0] exp_imm_drv;
  int          pushes_seen = 0;
  int          pops_seen   = 0;

  always @(negedge clk) begin
    if (sb_en && rst_n) begin
      sb_t e;
      check("in_ready_vs_occupancy", 64'(in_ready), 64'(sb_q.size() < 2));
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("pop_from_empty", 64'(out_valid), 64'd0);
        end else begin
          e = sb_q.pop_front();
          check("sb_tag", 64'(out_tag), 64'(e.tag));
          check("sb_imm", out_imm, e.imm);
          pop_log.push_back(out_tag);
          pops_seen++;
        end
      end
      if (in_valid && in_ready) begin
        sb_q.push_back('{in_tag, exp_imm_drv});
        pushes_seen++;
      end
    end
  end

  task automatic drive_addi(input int v, input logic [3:0] tag);
    in_valid    = 1'b1;
    in_instr    = {12'(v), 20'h00093};
    in_tag      = tag;
    exp_imm_drv = 64'(longint'(v));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;

    tbl[0]  = '{32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0, 32'hFFFF_FFFF, 3'd1, 1'b0};
    tbl[1]  = '{32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0, 32'hFFFF_FFFC, 3'd3, 1'b0};
    tbl[2]  = '{32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0, 32'h8000_0000, 3'd4, 1'b0};
    tbl[3]  = '{32'h0010006F, 64'h0000_0000_0000_0800, 3'd5, 1'b0, 32'h0000_0800, 3'd5, 1'b0};
    tbl[4]  = '{32'h0000001B, 64'h0,                   3'd1, 1'b0, 32'h0,         3'd0, 1'b1};
    tbl[5]  = '{32'hFE112E23, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0, 32'hFFFF_FFFC, 3'd2, 1'b0};
    tbl[6]  = '{32'h12345017, 64'h0000_0000_1234_5000, 3'd4, 1'b0, 32'h1234_5000, 3'd4, 1'b0};
    tbl[7]  = '{32'h7FF0A083, 64'h0000_0000_0000_07FF, 3'd1, 1'b0, 32'h0000_07FF, 3'd1, 1'b0};
    tbl[8]  = '{32'h80008067, 64'hFFFF_FFFF_FFFF_F800, 3'd1, 1'b0, 32'hFFFF_F800, 3'd1, 1'b0};
    tbl[9]  = '{32'h00000091, 64'h0,                   3'd0, 1'b1, 32'h0,         3'd0, 1'b1};
    tbl[10] = '{32'h0000007F, 64'h0,                   3'd0, 1'b1, 32'h0,         3'd0, 1'b1};
    tbl[11] = '{32'h002081B3, 64'h0,                   3'd0, 1'b1, 32'h0,         3'd0, 1'b1};
`ifdef IMM_GEN_CSR_EN
    tbl[12] = '{32'h0002D073, 64'h5,                   3'd6, 1'b0, 32'h5,         3'd6, 1'b0};
    tbl[13] = '{32'h00000073, 64'h0,                   3'd0, 1'b0, 32'h0,         3'd0, 1'b0};
`else
    tbl[12] = '{32'h0002D073, 64'h0,                   3'd0, 1'b1, 32'h0,         3'd0, 1'b1};
    tbl[13] = '{32'h00000073, 64'h0,                   3'd0, 1'b1, 32'h0,         3'd0, 1'b1};
`endif

    // Reset state
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b0;
    exp_imm_drv = '0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_imm",   out_imm,        64'd0);
    check("rst_out_fmt",   64'(out_fmt),   64'd0);
    check("rst_out_ill",   64'(out_illegal), 64'd0);
    check("rst_out_tag",   64'(out_tag),   64'd0);
    check("rst32_in_ready", 64'(in_ready32), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Table-driven decode, one instruction per cycle, out_ready high
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 14; i++) begin
      in_valid = 1'b1;
      in_instr = tbl[i].instr;
      in_tag   = 4'(i);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check($sformatf("v%0d_valid", i), 64'(out_valid),      64'd1);
      check($sformatf("v%0d_imm64", i), out_imm,             tbl[i].imm64);
      check($sformatf("v%0d_fmt64", i), 64'(out_fmt),        64'(tbl[i].fmt64));
      check($sformatf("v%0d_ill64", i), 64'(out_illegal),    64'(tbl[i].ill64));
      check($sformatf("v%0d_tag",   i), 64'(out_tag),        64'(i));
      check($sformatf("v%0d_imm32", i), 64'(out_imm32),      64'(tbl[i].imm32));
      check($sformatf("v%0d_fmt32", i), 64'(out_fmt32),      64'(tbl[i].fmt32));
      check($sformatf("v%0d_ill32", i), 64'(out_illegal32),  64'(tbl[i].ill32));
    end
    @(posedge clk); #1;
    check("drained_valid", 64'(out_valid), 64'd0);
    check("drained_imm",   out_imm,        64'd0);

    // Backpressure: tags 1,2 fill the buffer, tag 3 is held off until a pop
    sb_q.delete(); pop_log.delete();
    out_ready = 1'b0; sb_en = 1'b1;
    drive_addi(1, 4'd1);
    @(posedge clk); #1; drive_addi(2, 4'd2);
    @(posedge clk); #1; drive_addi(3, 4'd3);
    check("bp_full_in_ready", 64'(in_ready), 64'd0);
    check("bp_head_tag",      64'(out_tag),  64'd1);
    @(posedge clk); #1;
    check("bp_held_in_ready", 64'(in_ready), 64'd0);
    check("bp_held_tag",      64'(out_tag),  64'd1);
    check("bp_held_imm",      out_imm,       64'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_pop1_in_ready", 64'(in_ready), 64'd1);
    check("bp_pop1_tag",      64'(out_tag),  64'd2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_pop2_tag",      64'(out_tag),  64'd3);
    @(posedge clk); #1;
    check("bp_empty_valid",   64'(out_valid), 64'd0);
    check("bp_pop_count",     64'(pop_log.size()), 64'd3);
    for (int i = 0; i < pop_log.size() && i < 3; i++)
      check($sformatf("bp_order%0d", i), 64'(pop_log[i]), 64'(i + 1));

    // Stream of 16 with random out_ready
    sb_q.delete(); pushes_seen = 0; pops_seen = 0;
    budget = 0;
    while (pushes_seen < 16 && budget < 400) begin
      @(posedge clk); #1;
      budget++;
      out_ready = 1'($urandom_range(0, 1));
      if (pushes_seen < 16) drive_addi(pushes_seen * 37 - 300, 4'(pushes_seen));
      else in_valid = 1'b0;
    end
    in_valid = 1'b0;
    check("stream_pushes", 64'(pushes_seen), 64'd16);
    out_ready = 1'b1;
    budget = 0;
    while ((out_valid || sb_q.size() != 0) && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    check("stream_pops",     64'(pops_seen),   64'd16);
    check("stream_leftover", 64'(sb_q.size()), 64'd0);
    sb_en = 1'b0;

    // Asynchronous reset with two entries buffered
    out_ready = 1'b0;
    @(posedge clk); #1; drive_addi(1, 4'd1);
    @(posedge clk); #1; drive_addi(2, 4'd2);
    @(posedge clk); #1; in_valid = 1'b0;
    check("pre_rst_valid",    64'(out_valid), 64'd1);
    check("pre_rst_in_ready", 64'(in_ready),  64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid",    64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready),  64'd1);
    check("mid_rst_imm",      out_imm,        64'd0);
    check("mid_rst_tag",      64'(out_tag),   64'd0);
    check("mid_rst32_valid",  64'(out_valid32), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_addi(7, 4'd7);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("post_rst_valid", 64'(out_valid), 64'd1);
    check("post_rst_tag",   64'(out_tag),   64'd7);
    check("post_rst_imm",   out_imm,        64'd7);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_rst_drain", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised RV immediate generator between the fetch/decode register and the execute stage. Accepts one 32-bit instruction per cycle over a valid/ready handshake. Decodes the immediate format from the opcode and sign-extends to `XLEN`. Delivers the result, a format code and a caller tag through a 2-entry output buffer, so `in_ready` never depends combinationally on `out_ready`.

## Interface
- `XLEN`, 64 — immediate width; legal values are 32 and 64.
- `TAG_W`, 4 — width of the opaque tag carried with each instruction.
- `clk` in 1 — clock; all state updates on the rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `in_valid` in 1 — `in_instr`/`in_tag` are valid.
- `in_ready` out 1 — block can accept this cycle.
- `in_instr` in 32 — raw instruction word.
- `in_tag` in `TAG_W` — passed through unchanged.
- `out_valid` out 1 — head entry is valid.
- `out_ready` in 1 — consumer takes the head entry this cycle.
- `out_imm` out `XLEN` — decoded immediate.
- `out_fmt` out 3 — format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z.
- `out_illegal` out 1 — opcode not recognised.
- `out_tag` out `TAG_W` — tag of the head entry.

## Operation
- Transfer rules:
  - Input transfer occurs when `in_valid & in_ready`.
  - Output transfer occurs when `out_valid & out_ready`.
- Decode by `instr[6:0]`:
  - I-format: `0010011`, `0000011`, `1100111`; also `0011011` when `XLEN`=64. Immediate is `sext(instr[31:20])`.
  - S-format: `0100011` → `sext({instr[31:25],instr[11:7]})`.
  - B-format: `1100011` → `sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0})`.
  - U-format: `0110111`, `0010111` → `sext({instr[31:12],12'b0})`.
  - J-format: `1101111` → `sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0})`.
  - Z-format: see Configuration.
- Sign extension always uses `instr[31]` and fills to `XLEN`.
- Any other opcode, including `0011011` when `XLEN`=32 and any opcode with `instr[1:0]`≠`11`:
  - `out_imm`=0, `out_fmt`=0, `out_illegal`=1.
  - The entry still flows through the buffer in order.
- Decoding is combinational on the input side. The decoded fields plus the tag are written into the buffer.
- Buffer: 2 entries, FIFO order, a 2-bit count, and read/write pointers that wrap modulo 2.
  - `in_ready` = (count < 2). It is registered-equivalent and has no `out_ready` term.
  - Push and pop in the same cycle leave count unchanged and are legal at count 1.
  - At count 2, push is blocked. A pop alone takes count to 1, and `in_ready` rises the next cycle.
  - At count 0, pop is impossible because `out_valid`=0.
- Outputs always reflect the head entry. While `out_valid`=0, `out_imm`/`out_fmt`/`out_illegal`/`out_tag` are held at 0.

## Timing
- Latency: an instruction accepted in cycle N is presented on `out_*` in cycle N+1 when the buffer was empty or being drained.
- Throughput: 1 instruction per cycle with `out_ready` held high.
- Stability: the head entry is held stable while `out_valid & ~out_ready`.
- Reset (`rst_n` low, at any time, including mid-transfer):
  - count=0 and pointers=0.
  - `out_valid`=0, `in_ready`=1, all data outputs 0.
  - In-flight entries are discarded.
- Reset release: the first acceptance is possible on the first rising edge with `rst_n` high.

## Configuration
- `IMM_GEN_CSR_EN` defined: opcode `1110011` with `funct3`≠000 decodes as Z-format.
  - `out_imm` = `zext(instr[19:15])`, `out_fmt`=6, `out_illegal`=0.
  - `funct3`=000 (ECALL/EBREAK) gives `out_imm`=0, `out_fmt`=0, `out_illegal`=0.
- `IMM_GEN_CSR_EN` undefined: opcode `1110011` is unrecognised (`out_illegal`=1, `out_imm`=0). Code 6 is never produced.

## Test plan
- `XLEN`=64, `out_ready`=1:
  - push `0xFFF00093` → next cycle `out_imm`=`0xFFFF_FFFF_FFFF_FFFF`, fmt 1.
  - push `0xFE000EE3` → `0xFFFF_FFFF_FFFF_FFFC`, fmt 3.
- `XLEN`=64:
  - `0x800000B7` → `0xFFFF_FFFF_8000_0000`, fmt 4.
  - `0x0010006F` → `0x0000_0000_0000_0800`, fmt 5.
- `XLEN`=32: `0x0000001B` → `out_illegal`=1, `out_imm`=0, fmt 0. `XLEN`=64: same word → fmt 1, illegal 0.
- Backpressure, `out_ready`=0, `in_valid`=1 with tags 1, 2, 3:
  - Tags 1 and 2 are accepted, then `in_ready`=0 and tag 3 is held off.
  - Raise `out_ready` → order 1, 2, 3 out; no loss or duplication.
- Continuous stream of 16 instructions with `out_ready` toggling randomly → in-order output, and count never exceeds 2.
- Reset mid-operation: assert `rst_n`=0 with 2 entries buffered → `out_valid`=0 and `in_ready`=1 immediately (asynchronously).
- With `IMM_GEN_CSR_EN`: `0x0002D073` → `out_imm`=5, fmt 6. Without it: `out_illegal`=1.
